krz_gpio_bank: RTL and testbench
================================

# krz_gpio_bank

Parametrised Wishbone GPIO bank, successor to the fixed 12-pin GPIO registers in the KRZ general-purpose register block. Provides NPINS bidirectional pins with direction/output registers, atomic set/clear/toggle writes, byte-lane write enables, synchronised inputs and per-pin rising/falling-edge interrupts with write-1-to-clear pending bits. Sits on the KRZ peripheral Wishbone bus beside the UART and SPIM slaves; `irq` feeds the core's external interrupt line.

## Interface
- NPINS, 12, number of GPIO pins, 1..32; bits above NPINS-1 read 0, writes ignored
- SYNC_STAGES, 2, input synchroniser depth, 2..4
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- adr_i  input  6  byte address, bits [1:0] ignored
- dat_i  input  32  write data
- sel_i  input  4  byte-lane enables for writes
- we_i  input  1  1 = write, 0 = read
- stb_i  input  1  strobe (cyc folded in by interconnect)
- dat_o  output  32  read data, valid while ack_o high
- ack_o  output  1  single-cycle acknowledge
- gpio_dir  output  NPINS  1 = output driver enabled
- gpio_write  output  NPINS  output values
- gpio_read  input  NPINS  raw asynchronous pad inputs
- irq  output  1  level interrupt, OR of pending bits

## Operation
- Register map (byte offsets): DIR 0x00 RW; WRITE 0x04 RW; READ 0x08 RO (synchronised inputs); SET 0x0C WO (WRITE |= d); CLR 0x10 WO (WRITE &= ~d); TGL 0x14 WO (WRITE ^= d); RISE_EN 0x18 RW; FALL_EN 0x1C RW; PENDING 0x20 RW1C; INFO 0x24 RO = {16'h0, 8'(SYNC_STAGES), 8'(NPINS)}.
- Writes: only bytes with sel_i[k]=1 affect bits [8k+7:8k]; applies to every writable register including SET/CLR/TGL/PENDING masks.
- WO registers read 0; unmapped addresses read 0, ignore writes, still ack.
- Inputs: gpio_read passes SYNC_STAGES flops (sync) then one history flop (prev). rise = sync & ~prev & RISE_EN; fall = ~sync & prev & FALL_EN.
- PENDING[i] sets on rise[i]|fall[i]; clears on W1C. Same-cycle set and W1C: set wins.
- irq = |PENDING, registered.
- Reset values: dat_o 0, ack_o 0, gpio_dir 0 (inputs), gpio_write 0, RISE_EN 0, FALL_EN 0, PENDING 0, irq 0, sync/prev flops 0.

## Timing
- Registered-feedback classic cycle: stb_i sampled high with ack_o low -> ack_o high next cycle for exactly one cycle; ack_o then low for at least one cycle even if stb_i held (one access per two cycles).
- Write effect visible on outputs on the same edge ack_o rises.
- Read dat_o captured on the edge ack_o rises; held until next read.
- Pad-to-READ latency SYNC_STAGES cycles; pad edge to PENDING SYNC_STAGES+1 cycles; to irq +1.
- rst asserted mid-access: ack_o forced 0 next edge, access discarded.
- Enabling RISE_EN while pin already high does not create a pending bit (edge only).

## Configuration
- KRZ_GPIO_IRQ_EN defined: edge detection, RISE_EN/FALL_EN/PENDING, irq as above.
- Undefined: those registers and history flops removed; RISE_EN/FALL_EN/PENDING read 0, writes ignored; irq tied 0. READ and synchronisers remain.

## Structure
- krz_map package: add KRZ_GPIO_* offset constants (6-bit) and a typedef of register index enum; INFO layout constants.
- Sub-module krz_sync (SYNC_STAGES-deep, WIDTH-bit flop chain, reset to 0) instantiated for inputs; reusable by other peripherals.

## Test plan
- Reset, read all registers -> DIR/WRITE/READ(pads 0)/PENDING = 0, INFO = 0x0000020C for defaults.
- Write WRITE=0xFFF sel=4'b0001 -> WRITE reads 0x0FF; then CLR 0x00F -> 0x0F0; TGL 0x0FF -> 0x00F; SET 0x800 -> 0x80F; gpio_write matches each after ack.
- RISE_EN=0x001, pad0 0->1 -> PENDING=0x001 after 3 cycles, irq after 4; write PENDING=0x001 -> irq 0 one cycle after ack.
- FALL_EN=0x002, pad1 falls on same cycle as W1C of bit1 -> PENDING[1] stays 1.
- stb_i held high 6 cycles -> ack_o pattern 0,1,0,1,0,1; rst during ack -> ack_o 0, WRITE 0.
- Build without KRZ_GPIO_IRQ_EN, toggle pads with RISE_EN write -> PENDING reads 0, irq never high; NPINS=32 build: WRITE=0xFFFFFFFF reads back full.

Source files
------------

// File: rtl/krz_map.sv
// Shared KRZ peripheral address map: GPIO bank register offsets, register
// index type, address decoder and INFO word layout.
package krz_map;

  localparam logic [5:0] KRZ_GPIO_DIR     = 6'h00;
  localparam logic [5:0] KRZ_GPIO_WRITE   = 6'h04;
  localparam logic [5:0] KRZ_GPIO_READ    = 6'h08;
  localparam logic [5:0] KRZ_GPIO_SET     = 6'h0C;
  localparam logic [5:0] KRZ_GPIO_CLR     = 6'h10;
  localparam logic [5:0] KRZ_GPIO_TGL     = 6'h14;
  localparam logic [5:0] KRZ_GPIO_RISE_EN = 6'h18;
  localparam logic [5:0] KRZ_GPIO_FALL_EN = 6'h1C;
  localparam logic [5:0] KRZ_GPIO_PENDING = 6'h20;
  localparam logic [5:0] KRZ_GPIO_INFO    = 6'h24;

  localparam int KRZ_GPIO_INFO_NPINS_LSB = 0;
  localparam int KRZ_GPIO_INFO_SYNC_LSB  = 8;
  localparam int KRZ_GPIO_INFO_FIELD_W   = 8;

  typedef enum logic [3:0] {
    GPIO_REG_DIR,
    GPIO_REG_WRITE,
    GPIO_REG_READ,
    GPIO_REG_SET,
    GPIO_REG_CLR,
    GPIO_REG_TGL,
    GPIO_REG_RISE_EN,
    GPIO_REG_FALL_EN,
    GPIO_REG_PENDING,
    GPIO_REG_INFO,
    GPIO_REG_NONE
  } gpio_reg_e;

  // Word-aligned decode; the two byte-offset bits never select a register.
  function automatic gpio_reg_e krz_gpio_decode(input logic [5:0] adr);
    logic [5:0] a;
    a = {adr[5:2], 2'b00};
    case (a)
      KRZ_GPIO_DIR:     return GPIO_REG_DIR;
      KRZ_GPIO_WRITE:   return GPIO_REG_WRITE;
      KRZ_GPIO_READ:    return GPIO_REG_READ;
      KRZ_GPIO_SET:     return GPIO_REG_SET;
      KRZ_GPIO_CLR:     return GPIO_REG_CLR;
      KRZ_GPIO_TGL:     return GPIO_REG_TGL;
      KRZ_GPIO_RISE_EN: return GPIO_REG_RISE_EN;
      KRZ_GPIO_FALL_EN: return GPIO_REG_FALL_EN;
      KRZ_GPIO_PENDING: return GPIO_REG_PENDING;
      KRZ_GPIO_INFO:    return GPIO_REG_INFO;
      default:          return GPIO_REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/krz_sync.sv
// Generic multi-flop synchroniser for asynchronous inputs; STAGES deep,
// WIDTH bits wide, cleared by synchronous reset.
module krz_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_p [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) chain_p[i] <= '0;
    end else begin
      chain_p[0] <= d;
      for (int i = 1; i < STAGES; i++) chain_p[i] <= chain_p[i-1];
    end
  end

  assign q = chain_p[STAGES-1];

endmodule

// File: rtl/krz_gpio_bank.sv
// Wishbone GPIO bank with set/clear/toggle writes and synchronised inputs.
// Edge interrupts (RISE_EN/FALL_EN/PENDING, irq) exist only with KRZ_GPIO_IRQ_EN.
module krz_gpio_bank
  import krz_map::*;
#(
  parameter int NPINS       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       adr_i,
  input  logic [31:0]      dat_i,
  input  logic [3:0]       sel_i,
  input  logic             we_i,
  input  logic             stb_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic [NPINS-1:0] gpio_dir,
  output logic [NPINS-1:0] gpio_write,
  input  logic [NPINS-1:0] gpio_read,
  output logic             irq
);

  function automatic logic [NPINS-1:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return m[NPINS-1:0];
  endfunction

  function automatic logic [31:0] zext(input logic [NPINS-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NPINS-1:0] = v;
    return r;
  endfunction

  function automatic logic [NPINS-1:0] merge(input logic [NPINS-1:0] old,
                                             input logic [NPINS-1:0] d,
                                             input logic [NPINS-1:0] m);
    return (old & ~m) | (d & m);
  endfunction

  gpio_reg_e        idx;
  logic             access;
  logic             wr_acc;
  logic             rd_acc;
  logic [NPINS-1:0] mask;
  logic [NPINS-1:0] wd;
  logic [NPINS-1:0] sync_in;
  logic [NPINS-1:0] rise_en;
  logic [NPINS-1:0] fall_en;
  logic [NPINS-1:0] pend;
  logic [31:0]      rdata;
  logic [31:0]      info_word;
  logic             unused_bits;

  assign idx    = krz_gpio_decode(adr_i);
  assign access = stb_i & ~ack_o;
  assign wr_acc = access & we_i;
  assign rd_acc = access & ~we_i;
  assign mask   = lane_mask(sel_i);
  assign wd     = dat_i[NPINS-1:0] & mask;
  assign unused_bits = ^{adr_i[1:0], dat_i};

  always_comb begin
    info_word = '0;
    info_word[KRZ_GPIO_INFO_SYNC_LSB  +: KRZ_GPIO_INFO_FIELD_W] = 8'(SYNC_STAGES);
    info_word[KRZ_GPIO_INFO_NPINS_LSB +: KRZ_GPIO_INFO_FIELD_W] = 8'(NPINS);
  end

  krz_sync #(
    .WIDTH  (NPINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_read),
    .q   (sync_in)
  );

  // Bus handshake, output registers and read capture share the ack edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o      <= 1'b0;
      dat_o      <= '0;
      gpio_dir   <= '0;
      gpio_write <= '0;
    end else begin
      ack_o <= access;
      if (wr_acc) begin
        case (idx)
          GPIO_REG_DIR:   gpio_dir   <= merge(gpio_dir, dat_i[NPINS-1:0], mask);
          GPIO_REG_WRITE: gpio_write <= merge(gpio_write, dat_i[NPINS-1:0], mask);
          GPIO_REG_SET:   gpio_write <= gpio_write | wd;
          GPIO_REG_CLR:   gpio_write <= gpio_write & ~wd;
          GPIO_REG_TGL:   gpio_write <= gpio_write ^ wd;
          default: ;
        endcase
      end
      if (rd_acc) dat_o <= rdata;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      GPIO_REG_DIR:     rdata = zext(gpio_dir);
      GPIO_REG_WRITE:   rdata = zext(gpio_write);
      GPIO_REG_READ:    rdata = zext(sync_in);
      GPIO_REG_RISE_EN: rdata = zext(rise_en);
      GPIO_REG_FALL_EN: rdata = zext(fall_en);
      GPIO_REG_PENDING: rdata = zext(pend);
      GPIO_REG_INFO:    rdata = info_word;
      default:          rdata = '0;
    endcase
  end

`ifdef KRZ_GPIO_IRQ_EN
  logic [NPINS-1:0] prev_p;
  logic [NPINS-1:0] evt;
  logic [NPINS-1:0] w1c;

  assign evt = (sync_in & ~prev_p & rise_en) | (~sync_in & prev_p & fall_en);
  assign w1c = (wr_acc && idx == GPIO_REG_PENDING) ? wd : '0;

  // Edge history and pending state; a new event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p  <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      irq     <= 1'b0;
    end else begin
      prev_p <= sync_in;
      if (wr_acc && idx == GPIO_REG_RISE_EN) rise_en <= merge(rise_en, dat_i[NPINS-1:0], mask);
      if (wr_acc && idx == GPIO_REG_FALL_EN) fall_en <= merge(fall_en, dat_i[NPINS-1:0], mask);
      pend <= (pend & ~w1c) | evt;
      irq  <= |pend;
    end
  end
`else
  assign rise_en = '0;
  assign fall_en = '0;
  assign pend    = '0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_krz_gpio_bank.sv
// Directed bench for krz_gpio_bank: a 12-pin and a 32-pin instance share one bus.
// Interrupt scenarios follow whether KRZ_GPIO_IRQ_EN is defined for the build.
module tb_krz_gpio_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic [11:0] pads;

  logic [31:0] dat12, dat32;
  logic        ack12, ack32;
  logic [11:0] dir12, wr12;
  logic [31:0] dir32, wr32;
  logic        irq12, irq32;
  logic [31:0] pads32;

  int vec  = 0;
  int errs = 0;

  assign pads32 = {20'h0, pads};

  always #5 clk = ~clk;

  krz_gpio_bank #(.NPINS(12), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .sel_i(sel), .we_i(we),
    .stb_i(stb), .dat_o(dat12), .ack_o(ack12), .gpio_dir(dir12),
    .gpio_write(wr12), .gpio_read(pads), .irq(irq12)
  );

  krz_gpio_bank #(.NPINS(32), .SYNC_STAGES(2)) u_dut32 (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .sel_i(sel), .we_i(we),
    .stb_i(stb), .dat_o(dat32), .ack_o(ack32), .gpio_dir(dir32),
    .gpio_write(wr32), .gpio_read(pads32), .irq(irq32)
  );

  // Bus tasks are entered and left on a falling edge with ack low.
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; dat_w = d; sel = s; we = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); stb = 1'b0; we = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d12, output logic [31:0] d32);
    adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1;
    @(posedge clk); #1;
    d12 = dat12; d32 = dat32;
    @(negedge clk); stb = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic test_reset;
    logic [31:0] r, r32;
    rst = 1'b1; adr = '0; dat_w = '0; sel = '0; we = 1'b0; stb = 1'b0; pads = '0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (ack12 !== 1'b0) begin errs++; $display("FAIL reset_ack got %0b want 0", ack12); end
    vec++; if (dat12 !== 32'h0) begin errs++; $display("FAIL reset_dat got %h want 0", dat12); end
    vec++; if ({dir12, wr12} !== 24'h0) begin errs++; $display("FAIL reset_pins got %h want 0", {dir12, wr12}); end
    vec++; if (irq12 !== 1'b0) begin errs++; $display("FAIL reset_irq got %0b want 0", irq12); end
    @(negedge clk); rst = 1'b0;
    idle(2);
    bus_read(6'h00, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL reset_dir_rd got %h want 0", r); end
    bus_read(6'h04, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL reset_write_rd got %h want 0", r); end
    bus_read(6'h08, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL reset_read_rd got %h want 0", r); end
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL reset_pending_rd got %h want 0", r); end
    bus_read(6'h24, r, r32);
    vec++; if (r !== 32'h0000020C) begin errs++; $display("FAIL info12 got %h want 0000020c", r); end
    vec++; if (r32 !== 32'h00000220) begin errs++; $display("FAIL info32 got %h want 00000220", r32); end
    bus_read(6'h3C, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL unmapped_rd got %h want 0", r); end
  endtask

  task automatic test_wide;
    logic [31:0] r, r32;
    bus_write(6'h04, 32'hFFFF_FFFF, 4'hF);
    bus_read(6'h04, r, r32);
    vec++; if (r32 !== 32'hFFFF_FFFF) begin errs++; $display("FAIL wide_write32 got %h want ffffffff", r32); end
    vec++; if (r !== 32'h0000_0FFF) begin errs++; $display("FAIL wide_write12 got %h want 00000fff", r); end
    bus_write(6'h04, 32'h0, 4'hF);
  endtask

  task automatic test_set_clr_tgl;
    logic [31:0] r, r32;
    bus_write(6'h04, 32'h0000_0FFF, 4'b0001);
    bus_read(6'h04, r, r32);
    vec++; if (r !== 32'h0FF || wr12 !== 12'h0FF) begin errs++; $display("FAIL lane_write got rd %h pins %h want 0ff", r, wr12); end
    bus_write(6'h10, 32'h0000_000F, 4'hF);
    bus_read(6'h04, r, r32);
    vec++; if (r !== 32'h0F0 || wr12 !== 12'h0F0) begin errs++; $display("FAIL clr got rd %h pins %h want 0f0", r, wr12); end
    bus_write(6'h14, 32'h0000_00FF, 4'hF);
    bus_read(6'h04, r, r32);
    vec++; if (r !== 32'h00F || wr12 !== 12'h00F) begin errs++; $display("FAIL tgl got rd %h pins %h want 00f", r, wr12); end
    bus_write(6'h0C, 32'h0000_0800, 4'hF);
    bus_read(6'h04, r, r32);
    vec++; if (r !== 32'h80F || wr12 !== 12'h80F) begin errs++; $display("FAIL set got rd %h pins %h want 80f", r, wr12); end
    bus_write(6'h0C, 32'h0000_00F0, 4'b0010);
    vec++; if (wr12 !== 12'h80F) begin errs++; $display("FAIL set_lane got %h want 80f", wr12); end
    bus_read(6'h0C, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL set_rd got %h want 0", r); end
    bus_write(6'h00, 32'hFFFF_FFFF, 4'hF);
    bus_read(6'h00, r, r32);
    vec++; if (r !== 32'hFFF || dir12 !== 12'hFFF) begin errs++; $display("FAIL dir_full got rd %h pins %h want fff", r, dir12); end
    bus_write(6'h00, 32'h0000_0ABC, 4'b0010);
    bus_read(6'h00, r, r32);
    vec++; if (r !== 32'hAFF || dir12 !== 12'hAFF) begin errs++; $display("FAIL dir_lane got rd %h pins %h want aff", r, dir12); end
  endtask

  task automatic test_read_sync;
    logic [31:0] r, r32;
    pads = 12'h5A5;
    idle(1);
    bus_read(6'h08, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL sync_early got %h want 0", r); end
    bus_read(6'h08, r, r32);
    vec++; if (r !== 32'h5A5) begin errs++; $display("FAIL sync_late got %h want 5a5", r); end
    pads = 12'h0F0;
    idle(2);
    bus_read(6'h08, r, r32);
    vec++; if (r !== 32'h0F0) begin errs++; $display("FAIL sync_exact got %h want 0f0", r); end
    pads = 12'h000;
    idle(4);
  endtask

`ifdef KRZ_GPIO_IRQ_EN
  task automatic test_irq;
    logic [31:0] r, r32;
    bus_write(6'h18, 32'h001, 4'hF);
    idle(2);
    pads[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (irq12 !== 1'b0) begin errs++; $display("FAIL irq_early got %0b want 0", irq12); end
    @(posedge clk); #1;
    vec++; if (irq12 !== 1'b1) begin errs++; $display("FAIL irq_rise got %0b want 1", irq12); end
    @(negedge clk);
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h001) begin errs++; $display("FAIL pend_rise got %h want 001", r); end
    bus_write(6'h20, 32'h001, 4'hF);
    vec++; if (irq12 !== 1'b0) begin errs++; $display("FAIL irq_w1c got %0b want 0", irq12); end
    pads[2] = 1'b1;
    idle(6);
    bus_write(6'h18, 32'h005, 4'hF);
    idle(6);
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL en_level got %h want 0", r); end
    bus_write(6'h1C, 32'h002, 4'hF);
    pads[1] = 1'b1;
    idle(6);
    pads[1] = 1'b0;
    idle(6);
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h002) begin errs++; $display("FAIL pend_fall got %h want 002", r); end
    pads[1] = 1'b1;
    idle(6);
    pads[1] = 1'b0;
    idle(2);
    bus_write(6'h20, 32'h002, 4'hF);
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h002) begin errs++; $display("FAIL set_wins got %h want 002", r); end
    bus_write(6'h20, 32'h002, 4'b0010);
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h002) begin errs++; $display("FAIL w1c_lane got %h want 002", r); end
    bus_write(6'h20, 32'h002, 4'b0001);
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h0 || irq12 !== 1'b0) begin errs++; $display("FAIL w1c_clear got %h irq %0b want 0", r, irq12); end
    pads = 12'h000;
    bus_write(6'h18, 32'h0, 4'hF);
    bus_write(6'h1C, 32'h0, 4'hF);
    idle(4);
  endtask
`else
  task automatic test_irq;
    logic [31:0] r, r32;
    logic seen;
    seen = 1'b0;
    bus_write(6'h18, 32'hFFF, 4'hF);
    bus_write(6'h1C, 32'hFFF, 4'hF);
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) pads = ~pads;
      @(posedge clk); #1;
      if (irq12 !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL noirq_line got high want always 0"); end
    bus_read(6'h18, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL noirq_rise_en got %h want 0", r); end
    bus_read(6'h1C, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL noirq_fall_en got %h want 0", r); end
    bus_read(6'h20, r, r32);
    vec++; if (r !== 32'h0) begin errs++; $display("FAIL noirq_pending got %h want 0", r); end
    pads = 12'h000;
    idle(4);
  endtask
`endif

  task automatic test_back_to_back;
    adr = 6'h08; we = 1'b0; sel = 4'hF; stb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vec++;
      if (ack12 !== ((i % 2) == 1)) begin errs++; $display("FAIL ack_pattern[%0d] got %0b want %0b", i, ack12, (i % 2) == 1); end
      @(posedge clk); @(negedge clk);
    end
    stb = 1'b0;
    idle(2);
  endtask

  task automatic test_reset_mid;
    adr = 6'h04; dat_w = 32'h123; sel = 4'hF; we = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    vec++; if (ack12 !== 1'b1 || wr12 !== 12'h123) begin errs++; $display("FAIL pre_rst got ack %0b pins %h want 1 123", ack12, wr12); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vec++; if (ack12 !== 1'b0 || wr12 !== 12'h000) begin errs++; $display("FAIL rst_ack got ack %0b pins %h want 0 000", ack12, wr12); end
    @(negedge clk); dat_w = 32'h3C3;
    @(posedge clk); #1;
    vec++; if (ack12 !== 1'b0 || wr12 !== 12'h000) begin errs++; $display("FAIL rst_discard got ack %0b pins %h want 0 000", ack12, wr12); end
    @(negedge clk); rst = 1'b0; stb = 1'b0; we = 1'b0;
    idle(2);
    vec++; if (ack12 !== 1'b0 || wr12 !== 12'h000 || dir12 !== 12'h000) begin errs++; $display("FAIL post_rst got ack %0b pins %h dir %h want 0", ack12, wr12, dir12); end
  endtask

  initial begin
    test_reset();
    test_wide();
    test_set_clr_tgl();
    test_read_sync();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
